// File: rtl/mult_pkg.sv
// mult_pkg
//   Shared types and constants for the shift-add multiplier controller.
//   ctrl_state_t : controller state encoding
//   MULT_DW      : default operand width / iteration count
package mult_pkg;

    localparam int MULT_DW = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TEST,
        ADD,
        SHIFT,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/mult_iter_cnt.sv
// mult_iter_cnt
//   Loadable, saturating down counter that tracks remaining multiplier bits.
//   Ports:
//     clk    in   clock
//     reset  in   asynchronous active-high reset, clears count
//     ld     in   load count with dw (has priority over ena)
//     ena    in   decrement by one, sticks at zero
//     count  out  remaining iterations
module mult_iter_cnt
    import mult_pkg::*;
#(
    parameter int dw = MULT_DW,
    parameter int CW = $clog2(dw + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ld,
    input  logic          ena,
    output logic [CW-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (ld) begin
            count <= CW'(dw);
        end else if (ena && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// shift_add_mult_ctrl
//   Sequencer for a sequential shift-add multiplier datapath. Issues load,
//   then for each multiplier bit an optional add followed by a shift, and
//   reports busy/done to the host.
//   Ports:
//     clk       in   clock
//     reset     in   asynchronous active-high reset, forces IDLE
//     start     in   multiply request, honoured only in IDLE or DONE
//     mplr_lsb  in   current LSB of the datapath multiplier register
//     load      out  capture operands, clear accumulator
//     add_en    out  accumulator += multiplicand
//     shift_en  out  shift accumulator/multiplier right one bit
//     busy      out  high in LOAD, TEST, ADD, SHIFT
//     done      out  high in DONE
//     count     out  remaining iterations
//   Build option:
//     MULT_CTRL_DONE_HOLD_EN  when defined, DONE holds until the next start;
//                             otherwise done is a one-cycle pulse.
//
//   state | meaning
//   IDLE  | waiting for start, all outputs low
//   LOAD  | datapath captures operands, counter loads dw
//   TEST  | inspect multiplier LSB (updated at the previous edge)
//   ADD   | accumulate multiplicand for a set bit
//   SHIFT | shift datapath, consume one iteration
//   DONE  | result ready
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int dw = MULT_DW,
    parameter int CW = $clog2(dw + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          mplr_lsb,
    output logic          load,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] count
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;

    mult_iter_cnt #(
        .dw (dw),
        .CW (CW)
    ) u_iter_cnt (
        .clk   (clk),
        .reset (reset),
        .ld    (state == LOAD),
        .ena   (state == SHIFT),
        .count (count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = LOAD;
            LOAD:  state_nxt = TEST;
            TEST:  state_nxt = mplr_lsb ? ADD : SHIFT;
            ADD:   state_nxt = SHIFT;
            // count still holds the pre-decrement value here, so 1 means
            // this shift consumes the last bit.
            SHIFT: state_nxt = (count == CW'(1)) ? DONE : TEST;
            DONE: begin
`ifdef MULT_CTRL_DONE_HOLD_EN
                state_nxt = start ? LOAD : DONE;
`else
                state_nxt = start ? LOAD : IDLE;
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load     = 1'b0;
        add_en   = 1'b0;
        shift_en = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            LOAD: begin
                load = 1'b1;
                busy = 1'b1;
            end
            TEST: begin
                busy = 1'b1;
            end
            ADD: begin
                add_en = 1'b1;
                busy   = 1'b1;
            end
            SHIFT: begin
                shift_en = 1'b1;
                busy     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;
    import mult_pkg::*;

    localparam int DW = MULT_DW;
    localparam int CW = $clog2(DW + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mplr_lsb;
    logic          load, add_en, shift_en, busy, done;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    shift_add_mult_ctrl #(.dw(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .mplr_lsb (mplr_lsb),
        .load     (load),
        .add_en   (add_en),
        .shift_en (shift_en),
        .busy     (busy),
        .done     (done),
        .count    (count)
    );

    // datapath multiplier register model
    logic [DW-1:0] op_reg = '0;
    logic [DW-1:0] mreg;
    always @(posedge clk or posedge reset) begin
        if (reset)         mreg <= '0;
        else if (load)     mreg <= op_reg;
        else if (shift_en) mreg <= mreg >> 1;
    end
    assign mplr_lsb = mreg[0];

    typedef struct {
        logic [DW-1:0] op;
        int            lat;
        int            adds;
    } vec_t;

    typedef struct {
        int          lat;
        int          adds;
        int          shifts;
        logic [DW:0] mask;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // add_en should occur while count equals DW-i for every set bit i
    function automatic exp_t make_exp(input vec_t v);
        exp_t e;
        e.lat    = v.lat;
        e.adds   = v.adds;
        e.shifts = DW;
        e.mask   = '0;
        for (int i = 0; i < DW; i++)
            if (v.op[i]) e.mask[DW-i] = 1'b1;
        return e;
    endfunction

    // monitor
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          m_load_cyc = 0, m_adds = 0, m_shifts = 0, m_viol = 0;
    int          m_loads = 0, m_last_done_cyc = 0, m_gap = 0, ops_seen = 0;
    logic [DW:0] m_mask = '0;
    logic        m_prev_done = 1'b0, m_prev_add = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            m_prev_done = 1'b0;
            m_prev_add  = 1'b0;
        end else begin
            if (load) begin
                m_loads++;
                m_gap      = cyc - m_last_done_cyc;
                m_load_cyc = cyc;
                m_adds     = 0;
                m_shifts   = 0;
                m_mask     = '0;
                m_viol     = 0;
            end
            if ((int'(load) + int'(add_en) + int'(shift_en)) > 1) m_viol++;
            if ((load || add_en || shift_en) && !busy) m_viol++;
            if (busy && done) m_viol++;
            if (m_prev_add && !shift_en) m_viol++;
            if (add_en) begin
                m_adds++;
                m_mask[count] = 1'b1;
            end
            if (shift_en) begin
                if (int'(count) != DW - m_shifts) m_viol++;
                m_shifts++;
            end
            if (done && !m_prev_done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no result pending");
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("latency", cyc - m_load_cyc + 1, e.lat);
                    check("add_pulses", m_adds, e.adds);
                    check("shift_pulses", m_shifts, e.shifts);
                    check("add_positions", int'(m_mask), int'(e.mask));
                    check("done_count", int'(count), 0);
                    check("protocol_violations", m_viol, 0);
                end
                ops_seen++;
                m_last_done_cyc = cyc;
            end
            m_prev_done = done;
            m_prev_add  = add_en;
        end
    end

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            check("done_timeout", 0, 1);
            sb_q.delete();
        end
    endtask

    task automatic run_op(input vec_t v);
        @(negedge clk);
        op_reg = v.op;
        start  = 1'b1;
        sb_q.push_back(make_exp(v));
        @(negedge clk);
        start = 1'b0;
        wait_done();
    endtask

    vec_t vecs[7];

    initial begin
        int   loads0, ops0, nsh, n;
        bit   found;
        vec_t v;

        vecs[0] = '{op: 8'h00, lat: 18, adds: 0};
        vecs[1] = '{op: 8'hFF, lat: 26, adds: 8};
        vecs[2] = '{op: 8'h05, lat: 20, adds: 2};
        vecs[3] = '{op: 8'h80, lat: 19, adds: 1};
        vecs[4] = '{op: 8'h01, lat: 19, adds: 1};
        vecs[5] = '{op: 8'hA5, lat: 22, adds: 4};
        vecs[6] = '{op: 8'h3C, lat: 22, adds: 4};

        repeat (2) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_load", int'(load), 0);
        check("rst_add", int'(add_en), 0);
        check("rst_shift", int'(shift_en), 0);
        check("rst_count", int'(count), 0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // DONE exit behaviour with start held low
        run_op(vecs[3]);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
`ifdef MULT_CTRL_DONE_HOLD_EN
            check("done_hold", int'(done), 1);
`else
            check("done_pulse", int'(done), 0);
`endif
            check("post_done_busy", int'(busy), 0);
        end

        // start held across two operations, then pulsed while busy
        @(negedge clk);
        op_reg = 8'h00;
        start  = 1'b1;
        loads0 = m_loads;
        ops0   = ops_seen;
        sb_q.push_back(make_exp(vecs[0]));
        sb_q.push_back(make_exp(vecs[0]));
        n = 0;
        while (m_loads < loads0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            start = k[0];
        end
        start = 1'b0;
        n = 0;
        while (ops_seen < ops0 + 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("held_start_loads", m_loads - loads0, 2);
        check("held_start_ops", ops_seen - ops0, 2);
        check("b2b_load_gap", m_gap, 1);
        sb_q.delete();

        // reset during the third shift
        @(negedge clk);
        op_reg = 8'h00;
        start  = 1'b1;
        sb_q.push_back(make_exp(vecs[0]));
        @(negedge clk);
        start = 1'b0;
        nsh   = 0;
        found = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (shift_en && nsh == 2) begin
                found = 1'b1;
                break;
            end
            if (shift_en) nsh++;
            @(negedge clk);
        end
        check("reach_third_shift", int'(found), 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_shift", int'(shift_en), 0);
        check("mid_rst_add", int'(add_en), 0);
        check("mid_rst_load", int'(load), 0);
        check("mid_rst_done", int'(done), 0);
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        v = vecs[1];
        run_op(v);

        repeat (3) @(negedge clk);
        check("leftover_results", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
